// File: rtl/bitfusion_operand_sequencer.sv
// Splits one 8x8 multiply into four 4x4 slices for the fusion datapath, then
// shift-accumulates the returning psums into a 16-bit product.
`timescale 1ns/1ps
module bitfusion_operand_sequencer #(
    parameter int PSUM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [7:0]  i_op_in,
    input  logic [7:0]  i_op_weight,
    input  logic        i_op_s_in,
    input  logic        i_op_s_weight,
    output logic [3:0]  o_fu_in,
    output logic [3:0]  o_fu_weight,
    output logic [2:0]  o_fu_in_width,
    output logic [2:0]  o_fu_weight_width,
    output logic        o_fu_s_in,
    output logic        o_fu_s_weight,
    input  logic [7:0]  i_fu_psum,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [15:0] o_res_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              r_state;
    logic                r_op_ready;
    logic                r_res_valid;
    logic [15:0]         r_res_data;
    logic [15:0]         r_acc;
    logic [7:0]          r_in;
    logic [7:0]          r_w;
    logic                r_s_in;
    logic                r_s_w;
    logic [3:0]          r_fu_in;
    logic [3:0]          r_fu_w;
    logic                r_fu_s_in;
    logic                r_fu_s_w;
    logic                r_fu_vld;
    logic [1:0]          r_fu_k;
    logic [PSUM_LAT-1:0] r_tag_v;
    logic [1:0]          r_tag_k [PSUM_LAT];

    logic [1:0]          w_tag_k;
    logic                w_tag_vld;
    logic                w_tag_signed;
    logic [15:0]         w_ext;
    logic [15:0]         w_shifted;
    logic [15:0]         w_acc_sum;
    logic                w_last;

    // Slice k: bit0 selects the activation high nibble, bit1 the weight high
    // nibble; a nibble is signed only when it is the high half of a signed operand.
    function automatic logic [9:0] f_slice(input logic [1:0] k, input logic [7:0] a,
                                           input logic [7:0] b, input logic sa, input logic sb);
        logic [3:0] w_a;
        logic [3:0] w_b;
        w_a = k[0] ? a[7:4] : a[3:0];
        w_b = k[1] ? b[7:4] : b[3:0];
        return {w_a, w_b, sa & k[0], sb & k[1]};
    endfunction

    assign w_tag_k      = r_tag_k[PSUM_LAT-1];
    assign w_tag_vld    = r_tag_v[PSUM_LAT-1];
    assign w_tag_signed = (w_tag_k[0] & r_s_in) | (w_tag_k[1] & r_s_w);
    assign w_last       = w_tag_vld && (w_tag_k == 2'd3);

    always_comb begin
        w_ext = w_tag_signed ? {{8{i_fu_psum[7]}}, i_fu_psum} : {8'd0, i_fu_psum};
        case (w_tag_k)
            2'd0:    w_shifted = w_ext;
            2'd3:    w_shifted = w_ext << 8;
            default: w_shifted = w_ext << 4;
        endcase
    end

    assign w_acc_sum = r_acc + w_shifted;

    // Each tag follows its slice through the fusion latency so the psum lands
    // with the right shift and extension.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int i = 0; i < PSUM_LAT; i++) r_tag_k[i] <= 2'd0;
        end else begin
            r_tag_v[0] <= r_fu_vld;
            r_tag_k[0] <= r_fu_k;
            for (int i = PSUM_LAT - 1; i > 0; i--) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_k[i] <= r_tag_k[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= 16'd0;
            r_acc       <= 16'd0;
            r_in        <= 8'd0;
            r_w         <= 8'd0;
            r_s_in      <= 1'b0;
            r_s_w       <= 1'b0;
            r_fu_in     <= 4'd0;
            r_fu_w      <= 4'd0;
            r_fu_s_in   <= 1'b0;
            r_fu_s_w    <= 1'b0;
            r_fu_vld    <= 1'b0;
            r_fu_k      <= 2'd0;
        end else begin
            if (w_tag_vld) r_acc <= w_acc_sum;
            unique case (r_state)
                IDLE: begin
                    if (i_op_valid) begin
                        r_in       <= i_op_in;
                        r_w        <= i_op_weight;
                        r_s_in     <= i_op_s_in;
                        r_s_w      <= i_op_s_weight;
                        r_acc      <= 16'd0;
                        {r_fu_in, r_fu_w, r_fu_s_in, r_fu_s_w} <=
                            f_slice(2'd0, i_op_in, i_op_weight, i_op_s_in, i_op_s_weight);
                        r_fu_vld   <= 1'b1;
                        r_fu_k     <= 2'd0;
                        r_op_ready <= 1'b0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_fu_k == 2'd3) begin
                        {r_fu_in, r_fu_w, r_fu_s_in, r_fu_s_w} <= 10'd0;
                        r_fu_vld <= 1'b0;
                        r_state  <= DRAIN;
                    end else begin
                        {r_fu_in, r_fu_w, r_fu_s_in, r_fu_s_w} <=
                            f_slice(r_fu_k + 2'd1, r_in, r_w, r_s_in, r_s_w);
                        r_fu_k <= r_fu_k + 2'd1;
                    end
                end
                DRAIN: begin
                    if (w_last) begin
                        r_res_data  <= w_acc_sum;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_op_ready        = r_op_ready;
    assign o_res_valid       = r_res_valid;
    assign o_res_data        = r_res_data;
    assign o_fu_in           = r_fu_in;
    assign o_fu_weight       = r_fu_w;
    assign o_fu_s_in         = r_fu_s_in;
    assign o_fu_s_weight     = r_fu_s_w;
    assign o_fu_in_width     = 3'd4;
    assign o_fu_weight_width = 3'd4;

endmodule

// File: tb/tb_bitfusion_operand_sequencer.sv
// Bench for bitfusion_operand_sequencer: delayed fusion-datapath model, a
// cycle-timeline reference model checked every cycle, directed and random ops.
`timescale 1ns/1ps
module tb_bitfusion_operand_sequencer;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_s_in, op_s_weight, res_ready;
    logic [7:0]  op_in, op_weight;
    logic        o_op_ready, o_fu_s_in, o_fu_s_weight, o_res_valid;
    logic [3:0]  o_fu_in, o_fu_weight;
    logic [2:0]  o_fu_in_width, o_fu_weight_width;
    logic [7:0]  fu_psum;
    logic [15:0] o_res_data;

    always #5 clk = ~clk;

    bitfusion_operand_sequencer #(.PSUM_LAT(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_op_valid        (op_valid),
        .o_op_ready        (o_op_ready),
        .i_op_in           (op_in),
        .i_op_weight       (op_weight),
        .i_op_s_in         (op_s_in),
        .i_op_s_weight     (op_s_weight),
        .o_fu_in           (o_fu_in),
        .o_fu_weight       (o_fu_weight),
        .o_fu_in_width     (o_fu_in_width),
        .o_fu_weight_width (o_fu_weight_width),
        .o_fu_s_in         (o_fu_s_in),
        .o_fu_s_weight     (o_fu_s_weight),
        .i_fu_psum         (fu_psum),
        .o_res_valid       (o_res_valid),
        .i_res_ready       (res_ready),
        .o_res_data        (o_res_data)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input bit sa, input bit sb);
        int ia, ib;
        ia = sa ? int'($signed(a)) : int'(a);
        ib = sb ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    function automatic logic [7:0] slice_prod(input logic [3:0] a, input logic [3:0] b,
                                             input logic sa, input logic sb);
        int ia, ib;
        ia = sa ? int'($signed(a)) : int'(a);
        ib = sb ? int'($signed(b)) : int'(b);
        return 8'(ia * ib);
    endfunction

    // Fusion datapath model: product of the presented slice appears LAT cycles
    // later; random junk is driven whenever no real slice is due.
    logic       exp_issue = 1'b0;
    logic [7:0] fz_p [LAT] = '{default: 8'd0};
    logic       fz_v [LAT] = '{default: 1'b0};
    logic [7:0] junk = 8'd0;

    always @(posedge clk) begin
        fz_p[0] <= slice_prod(o_fu_in, o_fu_weight, o_fu_s_in, o_fu_s_weight);
        fz_v[0] <= exp_issue;
        for (int i = LAT - 1; i > 0; i--) begin
            fz_p[i] <= fz_p[i-1];
            fz_v[i] <= fz_v[i-1];
        end
        junk <= 8'($urandom);
    end

    assign fu_psum = fz_v[LAT-1] ? fz_p[LAT-1] : junk;

    // Reference timeline: accept in cycle A -> slices in C0..C0+3, result from
    // C0+4+LAT until the handshake; idle (ready, zeros) otherwise.
    int          cyc = 0;
    int          c0 = 0;
    int          rel;
    bit          busy = 0;
    logic [7:0]  m_in, m_w;
    bit          m_si, m_sw;
    logic [15:0] m_prod;
    int          e_in, e_w, e_si, e_sw;
    bit          e_valid;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("fu_in_width", o_fu_in_width, 4);
            chk("fu_weight_width", o_fu_weight_width, 4);
            if (!rst_n) begin
                busy = 0;
                exp_issue = 1'b0;
                chk("rst_op_ready", o_op_ready, 1);
                chk("rst_res_valid", o_res_valid, 0);
                chk("rst_res_data", o_res_data, 0);
                chk("rst_fu", {o_fu_in, o_fu_weight, o_fu_s_in, o_fu_s_weight}, 0);
            end else begin
                rel = cyc - c0;
                e_in = 0; e_w = 0; e_si = 0; e_sw = 0;
                exp_issue = busy && rel <= 3;
                e_valid = busy && rel >= 4 + LAT;
                if (exp_issue) begin
                    e_in = (rel == 1 || rel == 3) ? int'(m_in[7:4]) : int'(m_in[3:0]);
                    e_w  = (rel >= 2) ? int'(m_w[7:4]) : int'(m_w[3:0]);
                    e_si = (m_si && (rel == 1 || rel == 3)) ? 1 : 0;
                    e_sw = (m_sw && rel >= 2) ? 1 : 0;
                end
                chk("op_ready", o_op_ready, busy ? 0 : 1);
                chk("res_valid", o_res_valid, e_valid ? 1 : 0);
                chk("fu_in", o_fu_in, e_in);
                chk("fu_weight", o_fu_weight, e_w);
                chk("fu_s_in", o_fu_s_in, e_si);
                chk("fu_s_weight", o_fu_s_weight, e_sw);
                if (e_valid) chk("res_data", o_res_data, m_prod);
                if (e_valid && res_ready) begin
                    busy = 0;
                end else if (!busy && op_valid) begin
                    busy = 1;
                    c0 = cyc + 1;
                    m_in = op_in; m_w = op_weight; m_si = op_s_in; m_sw = op_s_weight;
                    m_prod = ref_mul(op_in, op_weight, op_s_in, op_s_weight);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        op_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    // hold >= 0: keep res_ready low for that many valid cycles; hold < 0: random.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sa, input bit sb,
                          input int hold, output logic [15:0] res);
        int t, nv;
        bit seen;
        res = 16'd0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_in = a; op_weight = b; op_s_in = sa; op_s_weight = sb;
        res_ready = 1'b0;
        @(negedge clk);
        chk("accept_ready", o_op_ready, 1);
        t = 0;
        while (!o_op_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0; nv = 0; seen = 0;
        forever begin
            @(posedge clk); #1;
            op_valid = 1'($urandom_range(0, 1));
            op_in = 8'($urandom); op_weight = 8'($urandom);
            op_s_in = 1'($urandom); op_s_weight = 1'($urandom);
            res_ready = (hold < 0) ? 1'($urandom_range(0, 1)) : (nv >= hold);
            @(negedge clk);
            if (o_res_valid && !seen) begin
                seen = 1;
                chk("latency", t, 4 + LAT);
            end
            if (o_res_valid && res_ready) begin
                res = o_res_data;
                break;
            end
            if (o_res_valid) nv++;
            t++;
            if (t > 100 + hold) begin
                n_total++;
                $display("FAIL result_timeout: no handshake after %0d cycles for 0x%0h x 0x%0h", t, a, b);
                break;
            end
        end
    endtask

    logic [7:0]  d_in   [6] = '{8'h25, 8'hF6, 8'h80, 8'hFF, 8'hFF, 8'h25};
    logic [7:0]  d_w    [6] = '{8'h13, 8'h07, 8'h80, 8'hFF, 8'h80, 8'h13};
    bit          d_si   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          d_sw   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int          d_hold [6] = '{0, 0, 1, 2, 0, 10};
    logic [15:0] d_exp  [6] = '{16'h02BF, 16'hFFBA, 16'h4000, 16'hFE01, 16'h8080, 16'h02BF};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  a, b;
        bit          sa, sb;
        int          h;
        rst_n = 1'b0;
        op_valid = 1'b0; op_in = 8'd0; op_weight = 8'd0;
        op_s_in = 1'b0; op_s_weight = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_op_ready", o_op_ready, 1);
        chk("init_res_valid", o_res_valid, 0);
        chk("init_res_data", o_res_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(d_in[i], d_w[i], d_si[i], d_sw[i], d_hold[i], r);
            chk($sformatf("directed%0d", i), r, d_exp[i]);
        end
        idle();

        // Abort an op two cycles into ISSUE; reset must act without a clock edge.
        @(posedge clk); #1;
        op_valid = 1'b1; op_in = 8'hA5; op_weight = 8'h3C; op_s_in = 1'b1; op_s_weight = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_op_ready", o_op_ready, 1);
        chk("async_res_valid", o_res_valid, 0);
        chk("async_res_data", o_res_data, 0);
        chk("async_fu_in", o_fu_in, 0);
        chk("async_fu_weight", o_fu_weight, 0);
        chk("async_fu_signs", {o_fu_s_in, o_fu_s_weight}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 0, r);
        chk("after_reset", r, 16'h000C);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            sa = 1'($urandom); sb = 1'($urandom);
            h = $urandom_range(0, 4);
            if (h == 4) h = -1;
            run_op(a, b, sa, sb, h, r);
            chk("random", r, ref_mul(a, b, sa, sb));
        end
        idle();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitfusion_operand_sequencer.md
Name: bitfusion_operand_sequencer

Overview:
- Upstream driver for the 4-bit fusion datapath (bitfusion_top).
- Accepts one 8b x 8b multiply request on a valid/ready interface and splits it into four 4b x 4b slice pairs with per-slice sign flags.
- Issues the slices on the fusion-top input bus, collects the returning 8-bit psums, and shift-accumulates them into a 16-bit product.
- Returns the product on a valid/ready result interface.

Parameters:
- PSUM_LAT, 2, cycles from slice presented on fu_* (cycle t) to matching fu_psum valid (cycle t+PSUM_LAT); legal range 1..7.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset. Asynchronous assert, active-low (fixed).
- op_valid  input  1  request valid.
- op_ready  output  1  request ready.
- op_in  input  8  activation operand.
- op_weight  input  8  weight operand.
- op_s_in  input  1  op_in is signed two's complement.
- op_s_weight  input  1  op_weight is signed.
- fu_in  output  4  slice activation to fusion top.
- fu_weight  output  4  slice weight to fusion top.
- fu_in_width  output  3  activation width to fusion top.
- fu_weight_width  output  3  weight width to fusion top.
- fu_s_in  output  1  slice activation signed.
- fu_s_weight  output  1  slice weight signed.
- fu_psum  input  8  psum from fusion top.
- res_valid  output  1  result valid.
- res_ready  input  1  result accepted.
- res_data  output  16  signed/unsigned 16-bit product, two's complement.

Behaviour:
- Reset values (async on rst_n=0):
  - state=IDLE, op_ready=1, res_valid=0, res_data=0.
  - fu_in=0, fu_weight=0, fu_s_in=0, fu_s_weight=0.
  - fu_in_width=3'd4, fu_weight_width=3'd4 (constant at all times).
  - Accumulator and in-flight tags cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: op_ready=1. Accept on op_valid&&op_ready; latch operands and flags; clear accumulator; go to ISSUE. Let C0 be the first cycle after the accept edge.
  - ISSUE: four cycles, slice index k=0..3. fu_* are registered and carry slice k in cycle C0+k. After k=3, go to DRAIN.
  - DRAIN: wait until the last psum has been captured, then go to DONE.
  - DONE: res_valid=1 and res_data stable. On res_valid&&res_ready, go to IDLE next cycle (op_ready=1 there).
- op_ready=0 in ISSUE, DRAIN and DONE. No overlap of operations.
- Slice order, with hi=[7:4] and lo=[3:0]:
  - k0: in_lo × w_lo, shift 0, s_in=0, s_w=0.
  - k1: in_hi × w_lo, shift 4, s_in=op_s_in, s_w=0.
  - k2: in_lo × w_hi, shift 4, s_in=0, s_w=op_s_weight.
  - k3: in_hi × w_hi, shift 8, s_in=op_s_in, s_w=op_s_weight.
- Outside ISSUE, fu_in/fu_weight/fu_s_* are driven to 0.
- Collection:
  - A PSUM_LAT-deep tag pipeline (valid + k) tracks each issued slice.
  - fu_psum for slice k is sampled at the end of cycle C0+k+PSUM_LAT.
  - Extension: sign-extend fu_psum to 16b if that slice's s_in|s_w, else zero-extend.
  - Shift left by the slice shift, then add into the accumulator mod 2^16.
  - fu_psum is ignored when no tag is valid.
- Latency: res_valid first high in cycle C0+4+PSUM_LAT (7 cycles after the accept cycle at default).
- Range: all 8x8 signed/unsigned/mixed products fit in 16b. 255×255=0xFE01; 255×(-128)=-32640.
- Boundaries:
  - res_ready held low: remain in DONE indefinitely, res_data unchanged.
  - res_ready high in the first DONE cycle: single-cycle res_valid pulse.
  - op_valid while busy: ignored (op_ready=0). Operands are sampled only at accept.
  - Back-to-back: a new accept is possible in the cycle after the result handshake. Minimum issue interval is PSUM_LAT+6 cycles.
  - rst_n low mid-ISSUE/DRAIN/DONE: everything returns to reset values immediately. In-flight psums are discarded. No res_valid is produced for the aborted op.

Test Plan:
- Unsigned: op_in=0x25, op_weight=0x13, s=0/0. Expect res_data=0x02BF, res_valid at C0+6. fu_* show slices (5,3),(2,3),(5,1),(2,1) in C0..C0+3.
- Mixed sign: op_in=0xF6 (s_in=1), op_weight=0x07 (s_w=0). Expect res_data=0xFFBA (-70). fu_s_in=1 only in k1/k3.
- Extremes:
  - 0x80×0x80 both signed → 0x4000.
  - 0xFF×0xFF unsigned → 0xFE01.
  - 0xFF unsigned × 0x80 signed → 0x8080 (-32640).
- Backpressure: res_ready low for 10 cycles. res_valid/res_data stable; op_ready=0; op_valid pulses ignored. Release, then accept the next op the following cycle.
- Reset mid-operation: assert rst_n=0 at C0+2. All outputs at reset values asynchronously. After release, a new op 0x03×0x04 → 0x000C with no residue.
- Latency sweep: PSUM_LAT=1 and 5 with a delayed behavioural fusion model. res_valid at C0+5 and C0+9; results match the reference multiply on 1000 random ops.
